// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider (div_iter).
package div_pkg;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  // Helper operates on a wide container; callers truncate to their own WIDTH.
  localparam int DIV_MAX_W = 128;

  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                    input logic               neg);
    return neg ? (~x + DIV_MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, try subtracting the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next,
  output logic             trial_ge
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor_mag};
  assign trial_ge = (shifted >= {1'b0, divisor_mag});
  // A failed trial implies shifted < divisor, so its top bit is zero.
  assign rem_next = trial_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], trial_ge};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
// Optional DIV_ITER_DBZ_FAST_EN: divide-by-zero completes one cycle after accept.
module div_iter
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output div_state_e       state_dbg
);

  // Handshake: start is sampled on each rising edge and accepted only while
  // busy=0; busy stays high for the whole operation; done pulses for exactly
  // one cycle when q/r/div_zero update, and a start on that edge is accepted.

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs_mag, dvd_orig;
  logic             q_sign, r_sign, zero_flag;

  logic [WIDTH-1:0] rem_next, quo_next, dvd_mag_in, dvs_mag_in, q_fin, r_fin;
  logic             trial_ge, accept, last_step, divisor_zero, fast_dbz;

  assign dvd_mag_in   = WIDTH'(cond_neg(DIV_MAX_W'(dividend), signed_op & dividend[WIDTH-1]));
  assign dvs_mag_in   = WIDTH'(cond_neg(DIV_MAX_W'(divisor), signed_op & divisor[WIDTH-1]));
  assign divisor_zero = (divisor == '0);
  assign accept       = (state == DIV_IDLE) && start;
  assign last_step    = (state == DIV_RUN) && (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ITER_DBZ_FAST_EN
  assign fast_dbz = accept & divisor_zero;
`else
  assign fast_dbz = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .quo         (quo),
    .divisor_mag (dvs_mag),
    .rem_next    (rem_next),
    .quo_next    (quo_next),
    .trial_ge    (trial_ge)
  );

  // Zero divisor overrides the sign fix-up: all-ones quotient, raw dividend.
  assign q_fin = zero_flag ? '1 : WIDTH'(cond_neg(DIV_MAX_W'(quo_next), q_sign));
  assign r_fin = zero_flag ? dvd_orig : WIDTH'(cond_neg(DIV_MAX_W'(rem_next), r_sign));

  assign busy      = (state == DIV_RUN);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (accept && !fast_dbz) state_next = DIV_RUN;
      DIV_RUN:  if (last_step)           state_next = DIV_IDLE;
      default:                           state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs_mag   <= '0;
      dvd_orig  <= '0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
      zero_flag <= 1'b0;
      q         <= '0;
      r         <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (fast_dbz) begin
          done     <= 1'b1;
          q        <= '1;
          r        <= dividend;
          div_zero <= 1'b1;
        end else begin
          cnt       <= '0;
          rem       <= '0;
          quo       <= dvd_mag_in;
          dvs_mag   <= dvs_mag_in;
          dvd_orig  <= dividend;
          q_sign    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_sign    <= signed_op & dividend[WIDTH-1];
          zero_flag <= divisor_zero;
        end
      end else if (state == DIV_RUN) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + CNT_W'(1);
        if (last_step) begin
          done     <= 1'b1;
          q        <= q_fin;
          r        <= r_fin;
          div_zero <= zero_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: 32-bit and 8-bit instances, table + random + sequences.
module tb_div_iter;
  import div_pkg::*;

  localparam int W = 32;
`ifdef DIV_ITER_DBZ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start, signed_op;
  logic [W-1:0] dividend, divisor, q, r;
  logic         busy, done, div_zero;
  div_state_e   state_dbg;

  logic         start8, signed_op8;
  logic [7:0]   dividend8, divisor8, q8, r8;
  logic         busy8, done8, div_zero8;
  div_state_e   state_dbg8;

  div_iter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .q(q), .r(r), .busy(busy),
    .done(done), .div_zero(div_zero), .state_dbg(state_dbg)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_op(signed_op8),
    .dividend(dividend8), .divisor(divisor8), .q(q8), .r(r8), .busy(busy8),
    .done(done8), .div_zero(div_zero8), .state_dbg(state_dbg8)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic [W-1:0] exp_z[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer truncating division with the divide-by-zero rule.
  function automatic void model(input int w, input bit s, input longint unsigned a,
                                input longint unsigned b, output longint unsigned qm,
                                output longint unsigned rm, output bit z);
    longint unsigned mask;
    longint sa, sb;
    mask = (longint'(1) << w) - 1;
    if (b == 0) begin
      qm = mask; rm = a; z = 1'b1;
      return;
    end
    z = 1'b0;
    if (s) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      qm = longint'(sa / sb) & mask;
      rm = longint'(sa % sb) & mask;
    end else begin
      qm = a / b;
      rm = a % b;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez);
    signed_op = s; dividend = a; divisor = b; start = 1'b1;
    exp_q.push_back(eq); exp_r.push_back(er); exp_z.push_back(W'(ez));
  endtask

  // Called at the falling edge right after the accepting edge; returns at the done cycle.
  task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
    int cnt = 1;
    int nb = 0;
    while (!done && cnt < 200) begin
      if (busy) nb++;
      @(negedge clock);
      cnt++;
    end
    check({tag, " latency"}, W'(cnt), W'(exp_lat));
    check({tag, " busy cycles"}, W'(nb), W'(exp_busy));
    check({tag, " done"}, W'(done), W'(1));
    check({tag, " q"}, q, exp_q.pop_front());
    check({tag, " r"}, r, exp_r.pop_front());
    check({tag, " div_zero"}, W'(div_zero), exp_z.pop_front());
  endtask

  function automatic int lat_of(input logic [W-1:0] b);
    return (FAST && b == '0) ? 1 : W + 1;
  endfunction

  function automatic int busy_of(input logic [W-1:0] b);
    return (FAST && b == '0) ? 0 : W;
  endfunction

  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                        input string tag);
    @(negedge clock);
    issue(s, a, b, eq, er, ez);
    @(negedge clock);
    start = 1'b0;
    wait_done(lat_of(b), busy_of(b), tag);
    @(negedge clock);
    check({tag, " done pulse width"}, W'(done), W'(0));
  endtask

  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input bit ez, input string tag);
    int cnt = 1;
    int nb = 0;
    @(negedge clock);
    signed_op8 = s; dividend8 = a; divisor8 = b; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    while (!done8 && cnt < 100) begin
      if (busy8) nb++;
      @(negedge clock);
      cnt++;
    end
    check({tag, " latency"}, W'(cnt), (FAST && b == 8'd0) ? W'(1) : W'(9));
    check({tag, " busy cycles"}, W'(nb), (FAST && b == 8'd0) ? W'(0) : W'(8));
    check({tag, " q"}, W'(q8), W'(eq));
    check({tag, " r"}, W'(r8), W'(er));
    check({tag, " div_zero"}, W'(div_zero8), W'(ez));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           s;
    logic [W-1:0] a, b, eq, er;
    bit           ez;
  } vec_t;

  vec_t tbl[8];

  initial begin
    longint unsigned mq, mr;
    bit mz;
    int seen;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    tbl[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[4] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[5] = '{1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[7] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};

    reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; signed_op8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (2) @(negedge clock);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset q", q, '0);
    check("reset r", r, '0);
    check("reset div_zero", W'(div_zero), '0);
    check("reset busy8", W'(busy8), '0);
    reset = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].er, tbl[i].ez, $sformatf("tbl%0d", i));

    // 8-bit instance
    run8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, "w8 200/3");
    run8(1'b1, 8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0, "w8 -128/3");
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a8, b8;
      bit s8;
      s8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = (i % 7 == 0) ? 8'd0 : 8'($urandom);
      model(8, s8, longint'(a8), longint'(b8), mq, mr, mz);
      run8(s8, a8, b8, 8'(mq), 8'(mr), mz, $sformatf("w8 rnd%0d", i));
    end

    // randomized 32-bit against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      bit s;
      int pick;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0: b = '0;
        1: begin b = '1; a = 32'h8000_0000; end
        2: b = 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(W, s, longint'(a), longint'(b), mq, mr, mz);
      run_op(s, a, b, W'(mq), W'(mr), mz, $sformatf("rnd%0d", i));
    end

    // start while busy is ignored; start on the done cycle is accepted
    @(negedge clock);
    issue(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    signed_op = 1'b1; dividend = 32'd555; divisor = 32'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(W + 1 - 9, W - 9, "ignored start");
    issue(1'b1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 1'b0);
    @(negedge clock);
    start = 1'b0;
    check("b2b busy after accept", W'(busy), W'(1));
    wait_done(W + 1, W, "b2b");
    @(negedge clock);
    check("b2b done pulse width", W'(done), W'(0));

    // asynchronous reset mid-operation
    @(negedge clock);
    issue(1'b0, 32'd12345, 32'd10, 32'd1234, 32'd5, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid reset busy", W'(busy), '0);
    check("mid reset done", W'(done), '0);
    check("mid reset q", q, '0);
    check("mid reset r", r, '0);
    check("mid reset div_zero", W'(div_zero), '0);
    exp_q.delete(); exp_r.delete(); exp_z.delete();
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("no done after reset", W'(seen), '0);
    run_op(1'b0, 32'd12345, 32'd10, 32'd1234, 32'd5, 1'b0, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
